// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared definitions for the nibble-serial subtractor: slice width, FSM states
// and the slice-counter width helper.
package sub_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // A single-slice configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_subtractor_slice.sv
// Combinational 4-bit subtract slice using borrow generate/propagate lookahead.
module borrow_lookahead_sub_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bi,
  output logic [3:0] d,
  output logic       bo
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = ~a & b;
  assign p = ~(a ^ b);

  assign c[0] = bi;
  assign c[1] = g[0] | (p[0] & bi);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & bi);

  assign d  = a ^ b ^ c;
  assign bo = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bi);

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one nibble per cycle through a
// single shared lookahead slice, with valid/ready on both sides.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  import sub_pkg::*;

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CW     = cnt_width(NSLICE);
  localparam int MSB    = WIDTH - 1;

  state_t          state;
  state_t          state_d;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] diff_r;
  logic            borrow_r;
  logic            bout_r;
  logic            ovf_r;
  logic            accept;
  logic            last;

  logic [SLICE_W-1:0] s_a;
  logic [SLICE_W-1:0] s_b;
  logic [SLICE_W-1:0] s_d;
  logic               s_bo;

  assign s_a = a_r[int'(cnt)*SLICE_W +: SLICE_W];
  assign s_b = b_r[int'(cnt)*SLICE_W +: SLICE_W];

  borrow_lookahead_sub_4bit u_slice (
    .a  (s_a),
    .b  (s_b),
    .bi (borrow_r),
    .d  (s_d),
    .bo (s_bo)
  );

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(NSLICE - 1)) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      a_r      <= '0;
      b_r      <= '0;
      diff_r   <= '0;
      borrow_r <= 1'b0;
      bout_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else if (accept) begin
      cnt      <= '0;
      a_r      <= a;
      b_r      <= b;
      diff_r   <= '0;
      borrow_r <= bin;
      bout_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else if (state == RUN) begin
      diff_r[int'(cnt)*SLICE_W +: SLICE_W] <= s_d;
      borrow_r <= s_bo;
      // Counter returns to 0 after the last slice so it never indexes past the operands.
      cnt <= last ? '0 : cnt + 1'b1;
      if (last) begin
        bout_r <= s_bo;
        ovf_r  <= (a_r[MSB] != b_r[MSB]) && (s_d[SLICE_W-1] != a_r[MSB]);
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign diff      = diff_r;
  assign bout      = bout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor (WIDTH=16).
module tb_nibble_serial_subtractor;

  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             ov;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];

  nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic bi);
    logic [WIDTH:0] full;
    exp_t e;
    full = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, bi};
    e.d  = full[WIDTH-1:0];
    e.bo = full[WIDTH];
    e.ov = (x[WIDTH-1] != y[WIDTH-1]) && (e.d[WIDTH-1] != x[WIDTH-1]);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, presents one operation for one accepting edge, records expectation.
  task automatic do_accept(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic bi, output bit ok);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    ok = in_ready;
    if (ok) begin
      in_valid = 1'b1;
      a = x;
      b = y;
      bin = bi;
      sb.push_back(model(x, y, bi));
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    if (!out_valid) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    checks++;
    if (diff !== 16'h0000 || bout !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_out: diff=%h bout=%b ovf=%b required 0000/0/0", diff, bout, ovf);
    end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] va[6] = '{16'h1234, 16'h0000, 16'h8000, 16'h0005, 16'h7FFF, 16'hA5C3};
    logic [WIDTH-1:0] vb[6] = '{16'h0234, 16'h0001, 16'h0001, 16'h0005, 16'hFFFF, 16'h3C5A};
    logic             vc[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bit ok;
    int n;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      do_accept(va[i], vb[i], vc[i], ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL basic_accept[%0d]: in_ready stayed 0, required 1", i);
        continue;
      end
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL basic_busy[%0d]: in_ready=%b required 0 during RUN", i, in_ready);
      end
      wait_valid(n);
      checks++;
      if (n != NSLICE) begin
        failures++;
        $display("FAIL basic_latency[%0d]: cycles=%0d required %0d", i, n, NSLICE);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (diff !== e.d || bout !== e.bo || ovf !== e.ov) begin
          failures++;
          $display("FAIL basic_result[%0d]: diff=%h bout=%b ovf=%b required %h/%b/%b",
                   i, diff, bout, ovf, e.d, e.bo, e.ov);
        end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    exp_t e;
    logic [WIDTH-1:0] held;
    int bad_valid = 0, bad_diff = 0, bad_ready = 0;
    do_accept(16'hC0DE, 16'h1F2E, 1'b1, ok);
    wait_valid(n);
    checks++;
    if (n < 0) begin
      failures++;
      $display("FAIL bp_valid: out_valid never rose, required within %0d cycles", NSLICE);
    end
    held = diff;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b1) bad_valid++;
      if (diff !== held) bad_diff++;
      if (in_ready !== 1'b0) bad_ready++;
    end
    checks++;
    if (bad_valid != 0) begin
      failures++;
      $display("FAIL bp_hold_valid: out_valid dropped %0d times, required 0", bad_valid);
    end
    checks++;
    if (bad_diff != 0) begin
      failures++;
      $display("FAIL bp_hold_diff: diff changed %0d times, required 0", bad_diff);
    end
    checks++;
    if (bad_ready != 0) begin
      failures++;
      $display("FAIL bp_in_ready: in_ready high %0d times in DONE, required 0", bad_ready);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if (diff !== e.d || bout !== e.bo || ovf !== e.ov) begin
        failures++;
        $display("FAIL bp_result: diff=%h bout=%b ovf=%b required %h/%b/%b",
                 diff, bout, ovf, e.d, e.bo, e.ov);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_run_isolation();
    bit ok;
    int n = 0;
    exp_t e;
    do_accept(16'h4321, 16'h1234, 1'b0, ok);
    while (!out_valid && n < 30) begin
      a   = WIDTH'($urandom);
      b   = WIDTH'($urandom);
      bin = 1'($urandom);
      tick();
      n++;
    end
    checks++;
    if (!out_valid) begin
      failures++;
      $display("FAIL iso_valid: out_valid=0 after %0d cycles, required 1", n);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if (diff !== e.d || bout !== e.bo || ovf !== e.ov) begin
        failures++;
        $display("FAIL iso_result: diff=%h bout=%b ovf=%b required %h/%b/%b",
                 diff, bout, ovf, e.d, e.bo, e.ov);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midrun();
    bit ok;
    int n;
    exp_t e;
    do_accept(16'hABCD, 16'h1234, 1'b1, ok);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    checks++;
    if (diff !== 16'h0000 || bout !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL midrst_out: diff=%h bout=%b ovf=%b required 0000/0/0", diff, bout, ovf);
    end
    do_accept(16'h00FF, 16'h000F, 1'b0, ok);
    wait_valid(n);
    checks++;
    if (n != NSLICE) begin
      failures++;
      $display("FAIL midrst_latency: cycles=%0d required %0d", n, NSLICE);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if (diff !== e.d || bout !== e.bo || ovf !== e.ov) begin
        failures++;
        $display("FAIL midrst_result: diff=%h bout=%b ovf=%b required %h/%b/%b",
                 diff, bout, ovf, e.d, e.bo, e.ov);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] oa[3] = '{16'h1111, 16'hF00F, 16'h7FFF};
    logic [WIDTH-1:0] ob[3] = '{16'h0222, 16'h0FF0, 16'h8000};
    logic             oc[3] = '{1'b0, 1'b1, 1'b1};
    int t[3];
    int idx = 0, got = 0, cyc = 0;
    exp_t e;
    out_ready = 1'b1;
    while (got < 3 && cyc < 80) begin
      if (out_valid) begin
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checks++;
          if (diff !== e.d || bout !== e.bo || ovf !== e.ov) begin
            failures++;
            $display("FAIL b2b_result[%0d]: diff=%h bout=%b ovf=%b required %h/%b/%b",
                     got, diff, bout, ovf, e.d, e.bo, e.ov);
          end
        end
        t[got] = cyc;
        got++;
      end
      if (in_ready) begin
        if (idx < 3) begin
          in_valid = 1'b1;
          a   = oa[idx];
          b   = ob[idx];
          bin = oc[idx];
          sb.push_back(model(oa[idx], ob[idx], oc[idx]));
          idx++;
        end else begin
          in_valid = 1'b0;
        end
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (got != 3) begin
      failures++;
      $display("FAIL b2b_count: results=%0d required 3", got);
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (t[i] - t[i-1] != NSLICE + 2) begin
          failures++;
          $display("FAIL b2b_spacing[%0d]: cycles=%0d required %0d", i, t[i] - t[i-1], NSLICE + 2);
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_run_isolation();
    test_reset_midrun();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
- Multi-cycle subtractor: computes diff = a - b - bin over WIDTH/4 cycles, one 4-bit slice per cycle, chaining the borrow between slices through a register.
- It is the inverse-operation counterpart to the team's 4-bit lookahead adder. Each slice uses borrow generate/propagate terms in place of carry generate/propagate.
- Sits in the datapath library as a low-area subtract unit.
- Has a valid/ready handshake on both input and output.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
- NSLICE, WIDTH/4, number of slice cycles; derived, not overridable.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  borrow-out; 1 when unsigned a < b + bin.
- ovf  output  1  signed two's-complement overflow of the subtraction.

Behaviour:
- Reset: rst sampled high at a clock edge forces the following, regardless of state (including mid-RUN; the in-flight operation is discarded):
  - state = IDLE, slice counter = 0
  - in_ready = 1, out_valid = 0
  - diff = 0, bout = 0, ovf = 0
- States:
  - IDLE: in_ready = 1. On in_valid && in_ready: latch a, b, bin into operand registers; clear the diff register; counter = 0; go to RUN.
  - RUN: in_ready = 0. Each cycle processes slice k = counter, i.e. bits [4k+3:4k]:
    - slice input borrow = registered borrow (bin for k = 0)
    - write slice diff into diff[4k+3:4k]; register slice borrow-out
    - counter increments
    - after slice NSLICE-1: bout = final borrow, ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]); go to DONE
  - DONE: out_valid = 1; diff, bout and ovf are stable. On out_ready: go to IDLE. in_ready stays 0 in DONE, so there is no same-cycle re-accept.
- Latency: out_valid rises exactly NSLICE cycles after the accepting edge (4 for WIDTH=16).
- Throughput: one result per NSLICE+2 cycles with out_ready held high.
- Slice logic per bit i:
  - borrow generate g = ~a & b
  - borrow propagate p = ~(a ^ b)
  - d = a ^ b ^ bi
  - bo = g | (p & bi)
  - slice borrow-out follows the lookahead form: g3 | p3g2 | p3p2g1 | p3p2p1g0 | p3p2p1p0·bi
- Operand inputs are ignored outside IDLE. Changes to a, b or bin during RUN have no effect.
- out_ready outside DONE is ignored.
- Backpressure: DONE holds indefinitely with all outputs unchanged until out_ready.
- diff is visible only as a registered value. Partial slices may be observable during RUN; consumers qualify with out_valid.

Decomposition:
- Shared package (sub_pkg):
  - SLICE_W = 4
  - state enum {IDLE, RUN, DONE}
  - counter width function clog2(NSLICE)
- Sub-module borrow_lookahead_sub_4bit:
  - purely combinational
  - inputs: a[3:0], b[3:0], bi
  - outputs: d[3:0], bo
  - instantiated once and muxed by the slice counter

Test Plan:
- WIDTH=16, a=0x1234, b=0x0234, bin=0 -> after 4 cycles: diff=0x1000, bout=0, ovf=0.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0. Borrow ripples through all four slices.
- a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1. Separately: a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, bout=1, ovf=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and diff stable, in_ready=0. Assert out_ready -> IDLE next cycle, in_ready=1. Also toggle a during RUN -> result unaffected.
- Reset mid-RUN (rst at slice 2) -> next cycle: in_ready=1, out_valid=0, diff=0, bout=0, ovf=0. A new operation a=0x00FF, b=0x000F completes with diff=0x00F0.
- Back-to-back: three operations with in_valid and out_ready held high -> results spaced NSLICE+2 = 6 cycles apart, each matching a reference model.
